axi_interconnect_fifogen_wptr_full: RTL

Write-side pointer and full-flag generator for the fifogen async FIFO.
- Owns the binary write pointer that feeds axi_interconnect_fifogen_dec2gray; the Gray copy crosses to the read domain.
- Synchronizes the read domain's Gray read pointer into the write clock and converts it back to binary.
- Produces full, almost-full, fill level, RAM write address and an overflow pulse.

---
 rtl/axi_interconnect_fifogen_wptr_full_pkg.sv | 15 +
 rtl/axi_interconnect_fifogen_gray2dec.sv | 38 +++
 rtl/axi_interconnect_fifogen_wptr_full.sv | 81 ++++++++
 3 files changed

// File: rtl/axi_interconnect_fifogen_wptr_full_pkg.sv
// Shared pointer-width/depth derivations and defaults for the fifogen write-side blocks.
package axi_interconnect_fifogen_wptr_full_pkg;

  localparam int unsigned DefSyncStages = 2;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // One extra pointer bit separates full from empty.
  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + 32'd1;
  endfunction

endpackage

// File: rtl/axi_interconnect_fifogen_gray2dec.sv
// Gray-to-binary converter, counterpart of dec2gray; optionally registered.
module axi_interconnect_fifogen_gray2dec #(
  parameter int unsigned DW         = 5,
  parameter bit          PIPLE_LINE = 1'b0
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic [DW-1:0] gray,
  output logic [DW-1:0] bin
);

  logic [DW-1:0] bin_c;

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < DW; i++) begin
      bin_c[i] = ^(gray >> i);
    end
  end

  if (PIPLE_LINE) begin : gen_pipe
    logic [DW-1:0] bin_q;
    always_ff @(posedge clk_sys) begin
      if (rst) begin
        bin_q <= '0;
      end else begin
        bin_q <= bin_c;
      end
    end
    assign bin = bin_q;
  end else begin : gen_comb
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk_sys, rst};
    assign bin            = bin_c;
  end

endmodule

// File: rtl/axi_interconnect_fifogen_wptr_full.sv
// Write-side pointer, read-pointer synchronizer and full/afull/level/overflow generation.
module axi_interconnect_fifogen_wptr_full
  import axi_interconnect_fifogen_wptr_full_pkg::*;
#(
  parameter int unsigned AW          = 4,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned AFULL_TH    = 14
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW:0]   rd_gptr_async,
  output logic          wr_accept,
  output logic [AW-1:0] wr_addr,
  output logic [AW:0]   wr_bptr,
  output logic          full,
  output logic          afull,
  output logic [AW:0]   wr_level,
  output logic          ovf
);

  localparam int unsigned PW     = ptr_width(AW);
  localparam int unsigned Depth  = fifo_depth(AW);
  localparam logic [PW-1:0] DepthW = PW'(Depth);
  localparam logic [PW-1:0] AfullW = PW'(AFULL_TH);

  logic [PW-1:0] wr_bptr_q, wr_bptr_nxt;
  logic [PW-1:0] wr_level_q, lvl_nxt;
  logic          full_q, afull_q, ovf_q;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rd_gsync, rd_bsync;

  assign rd_gsync = sync_q[SYNC_STAGES-1];

  axi_interconnect_fifogen_gray2dec #(
    .DW         (PW),
    .PIPLE_LINE (1'b0)
  ) u_rd_g2b (
    .clk_sys (clk_sys),
    .rst     (rst),
    .gray    (rd_gsync),
    .bin     (rd_bsync)
  );

  // Pushes are ignored while reset is asserted.
  assign wr_accept   = wr_en & ~full_q & ~rst;
  assign wr_bptr_nxt = wr_bptr_q + PW'(wr_accept);
  // Uses the current synced read pointer, so level/full can only be pessimistic.
  assign lvl_nxt     = wr_bptr_nxt - rd_bsync;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      wr_bptr_q  <= '0;
      wr_level_q <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync_q[0] <= rd_gptr_async;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      wr_bptr_q  <= wr_bptr_nxt;
      wr_level_q <= lvl_nxt;
      full_q     <= (lvl_nxt == DepthW);
      afull_q    <= (lvl_nxt >= AfullW);
      ovf_q      <= wr_en & full_q;
    end
  end

  assign wr_bptr  = wr_bptr_q;
  assign wr_addr  = wr_bptr_q[AW-1:0];
  assign wr_level = wr_level_q;
  assign full     = full_q;
  assign afull    = afull_q;
  assign ovf      = ovf_q;

endmodule
